// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file for the pipelined MIPS datapath.
//
// Two write ports (port 1 wins on an address collision), NUM_RD asynchronous read
// ports, and a sequential clear engine that zeroes one entry per clock after reset
// or after a Clear_req pulse. Ready is high once every entry has been cleared.
//
// Optional build macro: WRITE_BYPASS_EN
//   defined   - a read of an address being written this cycle returns the new data
//   undefined - such a read returns the old stored value
//
// Ports:
//   CLK        clock, all state updates on the rising edge
//   Reset      synchronous active-high reset, starts a full clear
//   Clear_req  pulse, starts a full clear when sampled while ready
//   Ready      1 = storage valid, reads and writes active
//   rd_addr    packed read addresses, port k = [k*ADDR_W +: ADDR_W]
//   rd_data    packed read data, port k = [k*DATA_W +: DATA_W]
//   we0/waddr0/wdata0  write port 0 (writeback)
//   we1/waddr1/wdata1  write port 1 (secondary writeback, higher priority)
module regfile_mp #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                     CLK,
    input  logic                     Reset,
    input  logic                     Clear_req,
    output logic                     Ready,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        waddr0,
    input  logic [DATA_W-1:0]        wdata0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        waddr1,
    input  logic [DATA_W-1:0]        wdata1
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic {StClear, StReady} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] mem [DEPTH];

    logic wr_ok;
    logic clr_en;
    logic wen0;
    logic wen1;

    // A write is only committed in READY on an edge that neither resets nor
    // starts a clear; address 0 is dropped when it is hardwired to zero.
    assign wr_ok  = (state_q == StReady) && !Reset && !Clear_req;
    assign clr_en = (state_q == StClear) && !Reset;
    assign wen0   = we0 && wr_ok && !((ZERO_REG != 0) && (waddr0 == '0));
    assign wen1   = we1 && wr_ok && !((ZERO_REG != 0) && (waddr1 == '0));

    assign Ready = (state_q == StReady);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            StClear: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = StReady;
                end
            end
            StReady: begin
                if (Clear_req) begin
                    state_d = StClear;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = StClear;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= StClear;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Storage has no reset of its own; the clear engine zeroes it.
    // Port 1 is written last so it wins a same-address collision.
    always_ff @(posedge CLK) begin
        if (clr_en) begin
            mem[idx_q] <= '0;
        end
        if (wen0) begin
            mem[waddr0] <= wdata0;
        end
        if (wen1) begin
            mem[waddr1] <= wdata1;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            logic [ADDR_W-1:0] ra;
            logic [DATA_W-1:0] rv;
            ra = rd_addr[k*ADDR_W +: ADDR_W];
            rv = mem[ra];
`ifdef WRITE_BYPASS_EN
            if (wen0 && (waddr0 == ra)) begin
                rv = wdata0;
            end
            if (wen1 && (waddr1 == ra)) begin
                rv = wdata1;
            end
`else
            // Old-value semantics: the new data appears on the next cycle.
`endif
            if ((ZERO_REG != 0) && (ra == '0)) begin
                rv = '0;
            end
            if (state_q != StReady) begin
                rv = '0;
            end
            rd_data[k*DATA_W +: DATA_W] = rv;
        end
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file for the pipelined MIPS datapath; successor to the fixed 32x32, 2-read/1-write register file.
- Adds configurable width, depth and read-port count, plus a second write port with defined priority.
- Clears storage with a sequential clear engine, on reset or on request, and reports completion through Ready.
- Sits between the decode stage (read ports) and the writeback stage (write ports).

Parameters:
DATA_W, 32, data word width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
NUM_RD, 2, number of asynchronous read ports (1..4)
ZERO_REG, 1, 1 = entry 0 hardwired to zero (writes to it dropped, reads return 0); 0 = entry 0 is ordinary storage

Ports:
CLK  in  1  clock; all state updates on rising edge
Reset  in  1  synchronous, active-high reset
Clear_req  in  1  pulse; starts a full clear sequence when sampled in READY
Ready  out  1  1 = READY state, storage valid
rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port k = bits [k*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  packed read data; port k = bits [k*DATA_W +: DATA_W]
we0  in  1  write enable, port 0 (writeback)
waddr0  in  ADDR_W  write address, port 0
wdata0  in  DATA_W  write data, port 0
we1  in  1  write enable, port 1 (secondary writeback)
waddr1  in  ADDR_W  write address, port 1
wdata1  in  DATA_W  write data, port 1

Behaviour:
- Only one clock domain, CLK. Reset is synchronous and active-high.
- FSM states: CLEAR, READY.
- Reset sampled high: state <= CLEAR, clear index <= 0, Ready <= 0. Storage contents are not directly reset; the clear engine zeroes them.
- CLEAR, per rising edge with Reset low:
  - mem[idx] <= 0, idx <= idx+1.
  - On the edge that clears entry DEPTH-1: state <= READY, Ready <= 1.
  - Ready therefore rises DEPTH edges after the first edge with Reset low.
- CLEAR, other rules:
  - we0/we1 are ignored.
  - Clear_req is ignored.
  - All rd_data ports read 0.
- READY:
  - Clear_req sampled high: state <= CLEAR, idx <= 0, Ready <= 0. No entry is cleared on that edge.
  - Any write presented on that same edge is dropped.
  - The next DEPTH edges perform the clear.
- Writes, READY only, rising edge:
  - weN=1: mem[waddrN] <= wdataN.
  - Both ports, same address: port 1 wins (wdata1 stored).
  - Both ports, different addresses: both stored.
  - ZERO_REG=1: writes to address 0 are dropped on either port.
- Reads:
  - Combinational: rd_data[k] = mem[rd_addr[k]], settling the same cycle.
  - Address 0 returns 0 when ZERO_REG=1.
  - Default (no macro): a read of an address being written this cycle returns the OLD value. The new value is visible from the next cycle.
- Reset asserted mid-CLEAR: index restarts at 0; a full DEPTH-cycle clear follows deassertion.
- Reset asserted in READY: behaves as above; all prior contents are lost after the clear.
- Index wrap: idx is ADDR_W bits. The CLEAR exit is taken at idx == DEPTH-1, so no wrap past DEPTH-1 is ever observed.

Optional Feature:
WRITE_BYPASS_EN
- Defined: write-through forwarding, READY state only.
  - If rd_addr[k] matches an enabled, non-dropped write this cycle, rd_data[k] returns that write's data in the same cycle.
  - Port 1 takes priority when both ports match.
  - No forwarding for address 0 when ZERO_REG=1.
  - Removes the need for a separate writeback-to-decode forwarding path.
- Undefined: no forwarding; old-value read semantics as in Behaviour.
- Both builds: CLEAR forces rd_data to 0 regardless of the macro.

Test Plan:
- Reset/clear timing: Reset high 2 cycles, then low -> Ready=0 for exactly 32 edges, Ready=1 after the 32nd. All 32 entries read 0.
- Basic write/read: we0=1, waddr0=5, wdata0=0xDEADBEEF; next cycle rd_addr port0=5 -> 0xDEADBEEF. Write to addr 0 -> reads 0.
- Port collision: we0=1 (addr 7, 0x11111111) and we1=1 (addr 7, 0x22222222) on the same edge -> addr 7 reads 0x22222222. Repeat with addrs 7/8 -> both values stored.
- Same-cycle read of a written address: write addr 3 = 0xA5A5A5A5 while rd_addr=3 -> 0xA5A5A5A5 same cycle with WRITE_BYPASS_EN, old value without; 0xA5A5A5A5 next cycle in both builds.
- Clear_req: fill addrs 1..31 with nonzero data, pulse Clear_req with we0=1 to addr 9 on the same edge -> Ready low 32 edges; addr 9 write dropped; all entries 0 afterwards.
- Reset mid-clear: assert Reset at clear index 12 -> after deassertion Ready stays low a full 32 edges; writes during CLEAR leave no effect.
